// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU op codes, flag bit
// positions and the response-register state encoding.
package alu_arbiter_pkg;

   // ALU operation codes driven on alu_ctrl
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Bit positions of the architectural flags inside the {N,Z,C,V} nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // One-entry response register occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

endpackage : alu_arbiter_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational: the priority
// pointer is owned by the caller, which advances it on each issue.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       enable,
   output logic [1:0] grant
);

   // Grant a lone requester outright; break a tie with the pointer owner
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      grant = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule : rr_arb2

// File: rtl/alu_arbiter.sv
// Shares one external 32-bit ALU between two requesters. Arbitrates with a
// round-robin pointer, drives the ALU with the winner's operands, captures
// the result in a one-entry response register and maintains NZCV flags.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter bit RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_ctrl,
   input  logic             req0_setf,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_ctrl,
   input  logic             req1_setf,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       flags
);

   rsp_state_e       r_state;
   rsp_state_e       w_state_nxt;
   logic             r_ptr;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_result;
   logic [3:0]       r_flags;

   logic             w_can_accept;
   logic [1:0]       w_grant;
   logic             w_issue;
   logic             w_issue_id;
   logic             w_setf;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [1:0]       w_alu_ctrl;

   // The register can take a new result when empty, or when the held one
   // leaves on this same edge. rsp_ready only reaches req_ready, never rsp_*.
   assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

   // Gating with rst_n keeps requests from being accepted during reset
   rr_arb2 u_rr_arb2 (
      .req    (req_valid),
      .ptr    (r_ptr),
      .enable (w_can_accept & rst_n),
      .grant  (w_grant)
   );

   assign req_ready  = w_grant;
   assign w_issue    = |w_grant;
   assign w_issue_id = w_grant[1];

   // Route the granted requester's fields to the ALU, zeros when idle
   always_comb begin
      w_alu_a    = '0;
      w_alu_b    = '0;
      w_alu_ctrl = ALU_ADD;
      w_setf     = 1'b0;
      if (w_grant[0]) begin
         w_alu_a    = req0_a;
         w_alu_b    = req0_b;
         w_alu_ctrl = req0_ctrl;
         w_setf     = req0_setf;
      end else if (w_grant[1]) begin
         w_alu_a    = req1_a;
         w_alu_b    = req1_b;
         w_alu_ctrl = req1_ctrl;
         w_setf     = req1_setf;
      end
   end

   assign alu_a    = w_alu_a;
   assign alu_b    = w_alu_b;
   assign alu_ctrl = w_alu_ctrl;

   // Response-register occupancy: fill on issue, drain when consumed alone
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_issue)               w_state_nxt = ST_FULL;
         ST_FULL:  if (rsp_ready && !w_issue) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // Occupancy state register with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Capture result, requester id, pointer and flags on each issue
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_flags      <= 4'b0000;
         r_ptr        <= RR_INIT;
      end else if (w_issue) begin
         r_rsp_id     <= w_issue_id;
         r_rsp_result <= alu_result;
         r_ptr        <= ~w_issue_id;
         if (w_setf) begin
            r_flags[FLAG_N] <= alu_n;
            r_flags[FLAG_Z] <= alu_z;
            r_flags[FLAG_C] <= alu_c;
            r_flags[FLAG_V] <= alu_v;
         end
      end
   end

   assign rsp_valid  = (r_state == ST_FULL);
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign flags      = r_flags;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU feeds the DUT, a
// reference model predicts grants, and a scoreboard of expected responses
// is filled at issue and compared while each response is held.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int WIDTH   = 32;
   localparam bit RR_INIT = 1'b0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]       req0_ctrl, req1_ctrl;
   logic             req0_setf, req1_setf;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [1:0]       alu_ctrl;
   logic             alu_n, alu_z, alu_c, alu_v;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       flags;

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] res;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state, written only by the monitor
   logic       m_full  = 1'b0;
   logic       m_ptr   = RR_INIT;
   logic [3:0] m_flags = 4'b0000;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH), .RR_INIT(RR_INIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_setf(req0_setf),
      .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_setf(req1_setf),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .flags(flags)
   );

   // ARM-style ALU: returns {N,Z,C,V,result}; C on SUB means no borrow
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         ALU_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND: r = a & b;
         default: r = a | b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Monitor: compare DUT against the model mid-cycle, then advance the model
   always @(negedge clk) begin
      logic [1:0]  m_grant;
      logic        m_can;
      logic [35:0] r;
      logic        id;
      m_grant = 2'b00;
      check("flags", flags, m_flags);
      check("rsp_valid", rsp_valid, m_full);
      if (m_full) begin
         if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
         else begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_result", rsp_result, sb[0].res);
         end
      end
      m_can = !m_full || rsp_ready;
      if (rst_n && m_can) begin
         case (req_valid)
            2'b01:   m_grant = 2'b01;
            2'b10:   m_grant = 2'b10;
            2'b11:   m_grant = m_ptr ? 2'b10 : 2'b01;
            default: m_grant = 2'b00;
         endcase
      end
      check("req_ready", req_ready, m_grant);
      check("alu_a", alu_a, m_grant[0] ? req0_a : (m_grant[1] ? req1_a : 32'd0));
      check("alu_b", alu_b, m_grant[0] ? req0_b : (m_grant[1] ? req1_b : 32'd0));
      check("alu_ctrl", alu_ctrl, m_grant[0] ? req0_ctrl : (m_grant[1] ? req1_ctrl : ALU_ADD));
      if (!rst_n) begin
         m_full = 1'b0; m_ptr = RR_INIT; m_flags = 4'b0000;
         sb.delete();
      end else begin
         if (m_full && rsp_ready && sb.size() > 0) void'(sb.pop_front());
         if (|m_grant) begin
            id = m_grant[1];
            r  = id ? alu_fn(req1_a, req1_b, req1_ctrl) : alu_fn(req0_a, req0_b, req0_ctrl);
            sb.push_back('{id: id, res: r[31:0]});
            m_full = 1'b1;
            m_ptr  = ~id;
            if (id ? req1_setf : req0_setf) m_flags = r[35:32];
         end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
         end
      end
   end

   // Present one request and hold it until accepted (bounded wait)
   task automatic do_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic setf, output int waited);
      @(posedge clk); #1;
      if (id) begin req1_a = a; req1_b = b; req1_ctrl = op; req1_setf = setf; end
      else    begin req0_a = a; req0_b = b; req0_ctrl = op; req0_setf = setf; end
      req_valid[id] = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (req_ready[id]) break;
         waited++;
         if (waited > 50) begin
            check("req_timeout", waited, 0);
            break;
         end
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
      req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = ALU_ADD; req0_setf = 1'b1;
      req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = ALU_SUB; req1_setf = 1'b1;

      // Reset with both requesters valid: nothing accepted, ALU idle
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rst_req_ready", req_ready, 2'b00);
         check("rst_rsp_valid", rsp_valid, 1'b0);
         check("rst_flags", flags, 4'b0000);
         check("rst_alu_a", alu_a, 32'd0);
         check("rst_alu_b", alu_b, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = 2'b00;

      // Single ADD with setf from requester 0
      do_req(1'b0, 32'd5, 32'd3, ALU_ADD, 1'b1, w);
      check("add_accept_wait", w, 0);
      @(negedge clk);
      check("add_valid", rsp_valid, 1'b1);
      check("add_id", rsp_id, 1'b0);
      check("add_result", rsp_result, 32'd8);
      check("add_flags", flags, 4'b0000);

      // SUB flag cases and a flag-preserving AND from requester 1
      do_req(1'b1, 32'd3, 32'd5, ALU_SUB, 1'b1, w);
      @(negedge clk);
      check("sub_neg_result", rsp_result, 32'hFFFF_FFFE);
      check("sub_neg_flags", flags, 4'b1000);
      do_req(1'b1, 32'd5, 32'd5, ALU_SUB, 1'b1, w);
      @(negedge clk);
      check("sub_zero_result", rsp_result, 32'd0);
      check("sub_zero_flags", flags, 4'b0110);
      do_req(1'b1, 32'h0000_00F0, 32'h0000_000F, ALU_AND, 1'b0, w);
      @(negedge clk);
      check("and_result", rsp_result, 32'd0);
      check("and_flags_kept", flags, 4'b0110);

      // Contention after reset: grants alternate starting with requester 0
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      req0_a = 32'd10;  req0_b = 32'd20; req0_ctrl = ALU_ADD; req0_setf = 1'b0;
      req1_a = 32'd100; req1_b = 32'd7;  req1_ctrl = ALU_SUB; req1_setf = 1'b1;
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: response held, no accepts, then resume without a bubble
      rsp_ready = 1'b0;
      req0_a = 32'd7; req0_b = 32'd2; req0_ctrl = ALU_OR; req0_setf = 1'b1;
      req_valid = 2'b01;
      @(negedge clk);
      check("bp_first_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req0_a = 32'd50; req0_b = 32'd8; req0_ctrl = ALU_SUB; req0_setf = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_ready_low", req_ready, 2'b00);
         check("bp_held_result", rsp_result, 32'd7);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_no_bubble", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      @(negedge clk);
      check("bp_second_result", rsp_result, 32'd42);
      check("bp_second_flags", flags, 4'b0010);

      // Reset while a response is held under backpressure
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req0_a = 32'd3; req0_b = 32'd5; req0_ctrl = ALU_SUB; req0_setf = 1'b1;
      req_valid = 2'b01;
      @(posedge clk); #1 req_valid = 2'b00;
      @(negedge clk);
      check("mid_pre_valid", rsp_valid, 1'b1);
      check("mid_pre_flags", flags, 4'b1000);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
      @(negedge clk);
      check("mid_rsp_valid", rsp_valid, 1'b0);
      check("mid_flags", flags, 4'b0000);
      check("mid_ptr_init", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_alu_arbiter
